mem_arbiter_2to1: RTL
=====================

# mem_arbiter_2to1

Two-to-one arbiter for the PicoRV32 native memory interface. Shares one memory/peripheral slave port between two masters (e.g. CPU core and a DMA engine, or two cores) with round-robin arbitration, one outstanding transaction at a time. Sits between the masters' `mem_*` buses and the on-chip RAM / memory-mapped IO decoder.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: slave-response watchdog limit, range 1..65535 (used only with `MEM_ARB_TIMEOUT_EN`).
- `TIMEOUT_RDATA`, 32'h0000_0000: read data returned on timeout.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_valid`, `m1_valid`  in  1  master request; held until that master's ready.
- `m0_instr`, `m1_instr`  in  1  request is an instruction fetch.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte strobes; 0 = read.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid while ready is high.
- `s_valid`  out  1  slave request.
- `s_instr`, `s_addr`, `s_wdata`, `s_wstrb`  out  1/32/32/4  registered copy of granted request.
- `s_ready`  in  1  slave completion.
- `s_rdata`  in  32  slave read data, sampled with `s_ready`.
- `grant`  out  1  index of master owning the current/last transaction.
- `busy`  out  1  high in BUSY and RESP.
- `timeout_err`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- FSM states IDLE, BUSY, RESP.
- IDLE: if any `mN_valid`, pick winner, latch its instr/addr/wdata/wstrb into slave registers, set `grant`, go BUSY. None valid: stay.
- Arbitration: only one valid → it wins. Both valid → master ≠ `last_grant` wins. `last_grant` updated on each grant; reset value 1, so m0 wins the first tie.
- BUSY: `s_valid`=1 with latched fields, stable until `s_ready`. On edge with `s_ready`=1: `s_valid`<=0, capture `s_rdata` to granted master's `rdata`, assert granted `mN_ready`, go RESP.
- RESP: granted `mN_ready`=1 for exactly this cycle; then IDLE. Master drops/changes valid after seeing ready, so IDLE never re-grants a completed request.
- Ungranted master's ready stays 0, its rdata holds last value; its valid may stay high indefinitely (it wins next tie).
- Master fields changing while not granted are ignored; granted fields are registered, so master changes mid-BUSY do not reach the slave.
- `s_rdata` captured for writes too (don't-care to master).
- Reset (any time, incl. mid-BUSY): state IDLE, all outputs 0, `last_grant`=1, timer 0; in-flight transaction abandoned, no ready issued.

## Timing
- Reset values: `m*_ready`, `m*_rdata`, `s_valid`, `s_instr`, `s_addr`, `s_wdata`, `s_wstrb`, `grant`, `busy`, `timeout_err` all 0.
- Request sampled at edge k in IDLE → `s_valid` high from cycle k+1.
- `s_ready` sampled at edge j → `mN_ready` high cycle j+1 (RESP), IDLE at j+2; earliest next grant sampled at edge j+2.
- With a 1-cycle slave: master valid-to-ready = 3 cycles; back-to-back throughput one transaction per 3 cycles minimum.
- All outputs registered; no combinational path master→slave or slave→master.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined: 16-bit counter cleared on entry to BUSY, increments each BUSY cycle without `s_ready`. When count reaches `TIMEOUT_CYCLES`: `s_valid`<=0, granted `mN_rdata`<=`TIMEOUT_RDATA`, `mN_ready`<=1, `timeout_err`<=1 (one cycle), go RESP. `s_ready` on the expiry edge takes priority (normal completion, no error).
- Undefined: no counter, BUSY waits forever, `timeout_err` tied 0.

## Structure
- `mem_arb_pkg`: FSM state encoding (IDLE/BUSY/RESP), counter width constant (16).
- Sub-module `mem_arb_timer`: watchdog counter (clear, enable, expiry output), instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Single master: m0 read 0x3FC, slave 1-cycle ready with rdata 0x0000_0042 → `s_addr`=0x3FC, `m0_ready` one pulse with `m0_rdata`=0x42, m1_ready stays 0.
- Tie: both valid same cycle after reset, m0 write 0x100=0xAAAA_5555 wstrb 1111, m1 read 0x200 → m0 granted first, then m1; `grant` 0 then 1; each ready exactly once.
- Fairness: both held valid for 6 transactions → grants alternate 0,1,0,1,0,1.
- Stall: slave holds `s_ready` low 20 cycles → `s_valid` and fields stable 20 cycles, no master ready until cycle after `s_ready`.
- Reset mid-BUSY: assert `reset` 3 cycles into a stalled transaction → all outputs 0 immediately, no ready pulse; after release, m0 wins tie.
- `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, slave never ready → `m0_ready`=1 with `m0_rdata`=0, `timeout_err` one pulse, 8 BUSY cycles after grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the 2:1 PicoRV32 memory arbiter.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_busy = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  localparam int c_cnt_w = 16;

endpackage

`default_nettype wire

// File: rtl/mem_arb_timer.sv
//------------------------------------------------------------------------------
// mem_arb_timer
// Slave-response watchdog; used only when MEM_ARB_TIMEOUT_EN is defined.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int WIDTH = c_cnt_w
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  // Fires on the edge that would bring the count up to LIMIT.
  assign expired = enable && (r_count == c_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter_2to1.sv
//------------------------------------------------------------------------------
// mem_arbiter_2to1
// Round-robin 2:1 arbiter for the PicoRV32 native memory bus; one transaction
// in flight. Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter_2to1
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  logic [1:0] r_state;
  logic       r_last_grant;

  logic w_any_valid;
  logic w_winner;
  logic w_expired;

  assign w_any_valid = m0_valid | m1_valid;
  // On a tie the master that did not win last time goes next.
  assign w_winner    = (m0_valid && m1_valid) ? ~r_last_grant : m1_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (c_cnt_w)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((r_state == c_st_idle) && w_any_valid),
    .enable  ((r_state == c_st_busy) && !s_ready),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_st_idle;
      r_last_grant <= 1'b1;
      m0_ready     <= 1'b0;
      m0_rdata     <= '0;
      m1_ready     <= 1'b0;
      m1_rdata     <= '0;
      s_valid      <= 1'b0;
      s_instr      <= 1'b0;
      s_addr       <= '0;
      s_wdata      <= '0;
      s_wstrb      <= '0;
      grant        <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      timeout_err <= 1'b0;

      case (r_state)
        c_st_idle: begin
          if (w_any_valid) begin
            if (w_winner) begin
              s_instr <= m1_instr;
              s_addr  <= m1_addr;
              s_wdata <= m1_wdata;
              s_wstrb <= m1_wstrb;
            end else begin
              s_instr <= m0_instr;
              s_addr  <= m0_addr;
              s_wdata <= m0_wdata;
              s_wstrb <= m0_wstrb;
            end
            grant        <= w_winner;
            r_last_grant <= w_winner;
            s_valid      <= 1'b1;
            busy         <= 1'b1;
            r_state      <= c_st_busy;
          end
        end

        c_st_busy: begin
          // A real response on the expiry edge wins over the watchdog.
          if (s_ready || w_expired) begin
            s_valid     <= 1'b0;
            timeout_err <= !s_ready;
            if (grant) begin
              m1_rdata <= s_ready ? s_rdata : TIMEOUT_RDATA;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= s_ready ? s_rdata : TIMEOUT_RDATA;
              m0_ready <= 1'b1;
            end
            r_state <= c_st_resp;
          end
        end

        c_st_resp: begin
          busy    <= 1'b0;
          r_state <= c_st_idle;
        end

        default: begin
          s_valid <= 1'b0;
          busy    <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
